// File: rtl/alu_exec_unit_if.sv
// Instruction/operand bus of the execute stage. The fetch path drives the
// instruction and operands. The execute unit returns the ALU result, the
// register-bank write enable, the flags and the LDR write-back target.
interface alu_exec_unit_if;
  logic [31:0] fetch;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] result;
  logic [15:0] en;
  logic        n;
  logic        z;
  logic        c;
  logic        v;
  logic [3:0]  ldrdest;
  logic [15:0] ldrdestdec;

  modport master (
    output fetch, s1, s2,
    input  result, en, n, z, c, v, ldrdest, ldrdestdec
  );

  modport slave (
    input  fetch, s1, s2,
    output result, en, n, z, c, v, ldrdest, ldrdestdec
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage of the 32-bit, 16-register processor: ALU with NZCV flags,
// one-hot register write-enable decode and LDR destination store.
module alu_exec_unit (
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  logic [3:0]         w_op;
  logic               w_s;
  logic [3:0]         w_rd;
  logic [31:0]        w_add_b;
  logic               w_add_cin;
  logic               w_is_arith;
  logic [32:0]        w_sum;
  logic [31:0]        w_result;
  logic [4:0]         w_amt;
  logic [4:0]         w_ridx;
  logic [5:0]         w_lidx;
  logic               w_c_nxt;
  logic               w_v_nxt;
  logic               w_upd;
  logic               w_unused_bits;

  logic               r_n, r_z, r_c, r_v;
  logic [3:0]         r_ldrdest;
  logic               r_pend;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    logic [15:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign w_op          = bus.fetch[27:24];
  assign w_s           = bus.fetch[23];
  assign w_rd          = bus.fetch[22:19];
  assign w_unused_bits = ^{bus.fetch[31:28], bus.fetch[18:0]};
  assign w_amt         = bus.s2[4:0];
  assign w_lidx        = 6'd32 - {1'b0, w_amt};
  assign w_ridx        = w_amt - 5'd1;

  // Adder operand selection: subtraction is s1 + ~s2 + carry-in, so the carry
  // out is directly NOT borrow for SUB/CMP/SBC.
  always_comb begin
    w_add_b    = bus.s2;
    w_add_cin  = 1'b0;
    w_is_arith = 1'b0;
    case (w_op)
      4'h3:       begin w_is_arith = 1'b1; end
      4'h4, 4'hC: begin w_add_b = ~bus.s2; w_add_cin = 1'b1; w_is_arith = 1'b1; end
      4'h5:       begin w_add_cin = r_c; w_is_arith = 1'b1; end
      4'h6:       begin w_add_b = ~bus.s2; w_add_cin = r_c; w_is_arith = 1'b1; end
      default:    begin w_add_b = bus.s2; end
    endcase
    w_sum = {1'b0, bus.s1} + {1'b0, w_add_b} + {32'd0, w_add_cin};
  end

  // Result mux and next carry/overflow; unaffected flags keep their value.
  always_comb begin
    w_result = '0;
    w_c_nxt  = r_c;
    w_v_nxt  = r_v;
    case (w_op)
      4'h0: w_result = bus.s1 & bus.s2;
      4'h1: w_result = bus.s1 | bus.s2;
      4'h2: w_result = bus.s1 ^ bus.s2;
      4'h3, 4'h4, 4'h5, 4'h6, 4'hC,
      4'hD, 4'hE: w_result = w_sum[31:0];
      4'h7: w_result = bus.s2;
      4'h8: w_result = ~bus.s2;
      4'h9: begin
        w_result = bus.s1 << w_amt;
        if (w_amt != 5'd0) w_c_nxt = bus.s1[w_lidx[4:0]];
      end
      4'hA: begin
        w_result = bus.s1 >> w_amt;
        if (w_amt != 5'd0) w_c_nxt = bus.s1[w_ridx];
      end
      4'hB: begin
        w_result = $unsigned($signed(bus.s1) >>> w_amt);
        if (w_amt != 5'd0) w_c_nxt = bus.s1[w_ridx];
      end
      default: w_result = '0;
    endcase
    if (w_is_arith) begin
      w_c_nxt = w_sum[32];
      w_v_nxt = (bus.s1[31] == w_add_b[31]) && (w_sum[31] != bus.s1[31]);
    end
  end

  assign w_upd = (w_s && (w_op <= 4'hB)) || (w_op == 4'hC);

  // Flag register: reset dominates, otherwise update only on S-suffixed ALU ops or CMP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (w_upd) begin
      r_n <= w_result[31];
      r_z <= (w_result == 32'd0);
      r_c <= w_c_nxt;
      r_v <= w_v_nxt;
    end
  end

  // LDR target capture: memory data returns one cycle later, so the write is
  // pending only for the cycle following an LDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ldrdest <= 4'd0;
      r_pend    <= 1'b0;
    end else if (w_op == 4'hD) begin
      r_ldrdest <= w_rd;
      r_pend    <= 1'b1;
    end else begin
      r_pend    <= 1'b0;
    end
  end

  assign bus.result     = w_result;
  assign bus.en         = (!reset && (w_op <= 4'hB)) ? onehot16(w_rd) : 16'h0000;
  assign bus.n          = r_n;
  assign bus.z          = r_z;
  assign bus.c          = r_c;
  assign bus.v          = r_v;
  assign bus.ldrdest    = r_ldrdest;
  assign bus.ldrdestdec = r_pend ? onehot16(r_ldrdest) : 16'h0000;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a reference model pushes the expected
// combinational and post-edge values when each instruction is driven; they are
// popped and compared once the DUT has produced them.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;
  alu_exec_unit_if bus ();

  alu_exec_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [15:0] en;
  } comb_t;

  typedef struct packed {
    logic [3:0]  nzcv;
    logic [3:0]  ld;
    logic [15:0] dec;
  } seq_t;

  comb_t q_comb[$];
  seq_t  q_seq[$];

  int n_cmp = 0;
  int n_err = 0;

  logic m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  logic [3:0] m_ld = 0;
  logic m_pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: computes the expected result/en, advances model state.
  task automatic model(input logic rst, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    logic [63:0] w;
    logic [31:0] r;
    logic        nc, nv;
    logic [4:0]  sh;
    comb_t ce;
    seq_t  se;
    sh = b[4:0];
    nc = m_c;
    nv = m_v;
    r  = 32'd0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3, 4'h5: begin
        t  = {1'b0, a} + {1'b0, b} + ((op == 4'h5) ? {32'd0, m_c} : 33'd0);
        r  = t[31:0];
        nc = t[32];
        nv = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h4, 4'hC: begin
        r  = a - b;
        nc = (a >= b);
        nv = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h6: begin
        r  = a - b - {31'd0, !m_c};
        nc = ({1'b0, a} >= ({1'b0, b} + {32'd0, !m_c}));
        nv = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h7: r = b;
      4'h8: r = ~b;
      4'h9: begin
        w = {32'd0, a} << sh;
        r = w[31:0];
        if (sh != 0) nc = w[32];
      end
      4'hA, 4'hB: begin
        r = (op == 4'hA) ? (a >> sh) : $unsigned($signed(a) >>> sh);
        if (sh != 0) nc = a[sh - 5'd1];
      end
      4'hD, 4'hE: r = a + b;
      default: r = 32'd0;
    endcase
    ce.res = r;
    ce.en  = (!rst && op <= 4'hB) ? (16'h1 << rd) : 16'h0;
    q_comb.push_back(ce);
    if (rst) begin
      {m_n, m_z, m_c, m_v} = 4'b0;
      m_ld = 0;
      m_pend = 0;
    end else begin
      if ((s && op <= 4'hB) || op == 4'hC) begin
        m_n = r[31];
        m_z = (r == 0);
        m_c = nc;
        m_v = nv;
      end
      if (op == 4'hD) begin
        m_ld = rd;
        m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end
    se.nzcv = {m_n, m_z, m_c, m_v};
    se.ld   = m_ld;
    se.dec  = m_pend ? (16'h1 << m_ld) : 16'h0;
    q_seq.push_back(se);
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] op, input logic s,
                      input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
    comb_t ce;
    seq_t  se;
    @(negedge clk);
    reset     = rst;
    bus.fetch = {4'h0, op, s, rd, 4'h1, 4'h2, 11'h0};
    bus.s1    = a;
    bus.s2    = b;
    model(rst, op, s, rd, a, b);
    #1;
    ce = q_comb.pop_front();
    chk({tag, ".result"}, bus.result, ce.res);
    chk({tag, ".en"}, {16'h0, bus.en}, {16'h0, ce.en});
    @(posedge clk);
    #1;
    se = q_seq.pop_front();
    chk({tag, ".nzcv"}, {28'h0, bus.n, bus.z, bus.c, bus.v}, {28'h0, se.nzcv});
    chk({tag, ".ldrdest"}, {28'h0, bus.ldrdest}, {28'h0, se.ld});
    chk({tag, ".ldrdestdec"}, {16'h0, bus.ldrdestdec}, {16'h0, se.dec});
  endtask

  initial begin
    reset     = 1'b1;
    bus.fetch = '0;
    bus.s1    = '0;
    bus.s2    = '0;
    // 1: reset edge, then signed-overflowing ADD
    step("rst", 1, 4'hF, 0, 4'd0, 32'd0, 32'd0);
    step("add_ovf", 0, 4'h3, 1, 4'd3, 32'h7FFFFFFF, 32'd1);
    // 2: CMP equal, then ADC with carry set
    step("cmp_eq", 0, 4'hC, 0, 4'd5, 32'd5, 32'd5);
    step("adc", 0, 4'h5, 0, 4'd2, 32'd1, 32'd1);
    // 3: SUB borrow, then MOV without S
    step("sub_brw", 0, 4'h4, 1, 4'd6, 32'd0, 32'd1);
    step("mov_ns", 0, 4'h7, 0, 4'd7, 32'd0, 32'h12345678);
    step("sbc", 0, 4'h6, 1, 4'd1, 32'd10, 32'd3);
    // 4: shifts
    step("lsl", 0, 4'h9, 1, 4'd8, 32'h80000001, 32'd1);
    step("asr", 0, 4'hB, 1, 4'd8, 32'h80000000, 32'd31);
    step("lsr0", 0, 4'hA, 1, 4'd8, 32'h0000F00F, 32'd0);
    step("lsr", 0, 4'hA, 1, 4'd15, 32'h0000F00F, 32'd4);
    step("mvn", 0, 4'h8, 1, 4'd0, 32'd0, 32'd0);
    // 5: LDR, NOP, NOP; back-to-back LDR; STR
    step("ldr9", 0, 4'hD, 0, 4'd9, 32'h100, 32'h4);
    step("nop1", 0, 4'hF, 0, 4'd0, 32'd1, 32'd2);
    step("nop2", 0, 4'hF, 0, 4'd0, 32'd0, 32'd0);
    step("ldr2", 0, 4'hD, 0, 4'd2, 32'h20, 32'h4);
    step("ldr11", 0, 4'hD, 0, 4'd11, 32'h30, 32'h8);
    step("str", 0, 4'hE, 1, 4'd12, 32'h40, 32'h8);
    // 6: LDR coinciding with reset
    step("ldr_pre", 0, 4'h3, 1, 4'd1, 32'hFFFFFFFF, 32'd1);
    step("ldr_rst", 1, 4'hD, 0, 4'd4, 32'h50, 32'h4);
    step("post_rst", 0, 4'hF, 0, 4'd0, 32'd0, 32'd0);
    // random coverage
    for (int i = 0; i < 40; i++) begin
      step("rand", 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom, $urandom);
    end
    if (q_comb.size() != 0 || q_seq.size() != 0)
      chk("queue_empty", q_comb.size() + q_seq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
